// File: rtl/fb_page_streamer.sv
// Frame buffer plus page-byte serialiser for an SSD1306-style display.
// The game logic writes whole pixel columns; on request the frame is
// streamed page-major (page 0 cols 0..COLS-1, page 1, ...) as bytes over a
// valid/ready interface. Each byte costs one LOAD and at least one PRESENT cycle.
module fb_page_streamer #(
   parameter int COLS         = 128,
   parameter int ROWS         = 64,
   parameter int AUTO_REFRESH = 0,
   localparam int CW          = $clog2(COLS),
   localparam int PAGES       = ROWS / 8,
   localparam int PW          = (PAGES > 1) ? $clog2(PAGES) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] fb_col_w_data,
   input  logic [CW-1:0]   fb_col_sel,
   input  logic            fb_write,
   input  logic            frame_req,
   output logic [7:0]      out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_first,
   output logic            out_last,
   output logic            busy,
   output logic            frame_done
);

   typedef enum logic [1:0] {IDLE, LOAD, PRESENT} state_t;

   state_t state, state_n;

   logic [ROWS-1:0]        mem [COLS];
   logic [CW-1:0]          col;
   logic [PW-1:0]          page;
   logic [PAGES-1:0][7:0]  rd_pages;
   logic                   go;
   logic                   last_col;
   logic                   last_page;

   // The addressed column viewed as one byte per page.
   assign rd_pages  = mem[col];
   assign go        = frame_req || (AUTO_REFRESH != 0);
   assign last_col  = (col == CW'(COLS - 1));
   assign last_page = (page == PW'(PAGES - 1));
   assign busy      = (state != IDLE);

   // Column write port; runs regardless of the streamer, so a write in a
   // LOAD cycle lands after the read and shows up only in later bytes.
   always_ff @(posedge clk) begin
      if (fb_write)
         mem[fb_col_sel] <= fb_col_w_data;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Next-state logic: IDLE -> LOAD -> PRESENT -> (LOAD | IDLE).
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (go) state_n = LOAD;
         LOAD:    state_n = PRESENT;
         PRESENT: if (out_ready) state_n = out_last ? IDLE : LOAD;
         default: state_n = IDLE;
      endcase
   end

   // Output byte register, page/column walk and frame_done pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_first  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
         page       <= '0;
         col        <= '0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (go) begin
                  page <= '0;
                  col  <= '0;
               end
            end
            LOAD: begin
               out_data  <= rd_pages[page];
               out_first <= (page == '0) && (col == '0);
               out_last  <= last_page && last_col;
               out_valid <= 1'b1;
            end
            PRESENT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     frame_done <= 1'b1;
                  end else if (last_col) begin
                     col  <= '0;
                     page <= page + 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_page_streamer.sv
// Randomised bench for fb_page_streamer: a column-array model predicts each
// page-major byte by index, with random backpressure, a LOAD-cycle write
// collision, a mid-frame request, a mid-frame reset and an auto-refresh copy.
module tb_fb_page_streamer;

   localparam int COLS  = 128;
   localparam int ROWS  = 64;
   localparam int NBYTE = COLS * ROWS / 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [ROWS-1:0] fb_col_w_data = '0;
   logic [6:0]      fb_col_sel = '0;
   logic            fb_write = 1'b0;
   logic            frame_req = 1'b0;
   logic            out_ready = 1'b0;
   logic [7:0]      out_data, ar_data;
   logic            out_valid, out_first, out_last, busy, frame_done;
   logic            ar_valid, ar_first, ar_last, ar_busy, ar_done;

   int checks = 0;
   int errors = 0;
   logic [ROWS-1:0] ref_mem [COLS];

   always #5 clk = ~clk;

   fb_page_streamer #(.COLS(COLS), .ROWS(ROWS), .AUTO_REFRESH(0)) dut (
      .clk(clk), .rst(rst), .fb_col_w_data(fb_col_w_data), .fb_col_sel(fb_col_sel),
      .fb_write(fb_write), .frame_req(frame_req), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first),
      .out_last(out_last), .busy(busy), .frame_done(frame_done));

   fb_page_streamer #(.COLS(COLS), .ROWS(ROWS), .AUTO_REFRESH(1)) dut_ar (
      .clk(clk), .rst(rst), .fb_col_w_data(fb_col_w_data), .fb_col_sel(fb_col_sel),
      .fb_write(fb_write), .frame_req(frame_req), .out_data(ar_data),
      .out_valid(ar_valid), .out_ready(out_ready), .out_first(ar_first),
      .out_last(ar_last), .busy(ar_busy), .frame_done(ar_done));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Byte n of the frame: page n/COLS of column n%COLS.
   function automatic logic [7:0] exp_byte(input int n);
      logic [ROWS-1:0] w;
      w = ref_mem[n % COLS];
      return w[(n / COLS) * 8 +: 8];
   endfunction

   // Called at a negedge; write lands on the next posedge.
   task automatic write_col(input int c, input logic [ROWS-1:0] d);
      fb_write      = 1'b1;
      fb_col_sel    = 7'(c);
      fb_col_w_data = d;
      ref_mem[c]    = d;
      @(negedge clk);
      fb_write = 1'b0;
   endtask

   task automatic run_frame(input int rdy_pct, input bit collide, input bit mid_req,
                            input int abort_at);
      int hs, fd, cyc;
      bit pend_v;
      logic [ROWS-1:0] pend;
      hs = 0; fd = 0; cyc = 0; pend_v = 1'b0; pend = '0;
      frame_req = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      frame_req = 1'b0;
      chk("lat_busy", busy, 1);
      chk("lat_novalid", out_valid, 0);
      @(negedge clk);
      chk("lat_valid", out_valid, 1);
      while (fd == 0 && cyc < 6000) begin
         fb_write  = 1'b0;
         frame_req = 1'b0;
         if (frame_done) begin
            fd++;
            chk("done_at", hs, NBYTE);
         end else begin
            chk("busy", busy, 1);
            if (abort_at > 0 && hs == abort_at && out_valid) begin
               rst = 1'b0;
               out_ready = 1'b0;
               @(negedge clk);
               chk("abort_valid", out_valid, 0);
               chk("abort_busy", busy, 0);
               chk("abort_done", frame_done, 0);
               rst = 1'b1;
               repeat (3) begin
                  @(negedge clk);
                  chk("abort_nodone", frame_done, 0);
                  chk("abort_idle", busy, 0);
               end
               return;
            end
            if (collide && hs == 389 && !out_valid && !pend_v) begin
               pend          = ~ref_mem[5];
               pend_v        = 1'b1;
               fb_write      = 1'b1;
               fb_col_sel    = 7'd5;
               fb_col_w_data = pend;
            end
            if (mid_req && hs == 500) frame_req = 1'b1;
            if (out_valid) begin
               if (hs >= NBYTE) chk("extra_byte", hs, NBYTE - 1);
               else begin
                  chk("data", out_data, exp_byte(hs));
                  chk("first", out_first, hs == 0);
                  chk("last", out_last, hs == NBYTE - 1);
               end
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            if (out_valid && out_ready) begin
               if (pend_v && hs == 389) ref_mem[5] = pend;
               hs++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      fb_write  = 1'b0;
      frame_req = 1'b0;
      chk("hs_count", hs, NBYTE);
      chk("done_count", fd, 1);
      repeat (3) begin
         chk("post_done", frame_done, 0);
         chk("post_busy", busy, 0);
         chk("post_valid", out_valid, 0);
         @(negedge clk);
      end
   endtask

   initial begin
      int cyc;
      // Reset held with a pending request: nothing may start.
      rst = 1'b0;
      frame_req = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_valid", out_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", frame_done, 0);
         chk("rst_data", out_data, 0);
         chk("rst_first", out_first, 0);
      end
      frame_req = 1'b0;
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("idle_valid", out_valid, 0);
         chk("idle_busy", busy, 0);
      end

      for (int c = 0; c < COLS; c++) begin
         if (c == 0)              write_col(c, 64'h0000_0000_0000_00A5);
         else if (c == COLS - 1)  write_col(c, 64'hFF00_0000_0000_0000);
         else                     write_col(c, {$urandom, $urandom});
      end
      @(negedge clk);

      run_frame(100, 1'b0, 1'b0, 0);   // full speed, fixed corner columns
      run_frame(40,  1'b0, 1'b0, 0);   // heavy backpressure
      run_frame(70,  1'b1, 1'b1, 0);   // LOAD collision + ignored mid-frame request
      run_frame(60,  1'b0, 1'b0, 300); // reset-abort at byte 300
      run_frame(100, 1'b0, 1'b0, 0);   // clean restart after abort

      // Auto-refresh copy: next first byte two cycles after frame_done.
      out_ready = 1'b1;
      cyc = 0;
      while (!ar_done && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      chk("ar_done_seen", ar_done, 1);
      chk("ar_done_idle", ar_busy, 0);
      @(negedge clk);
      chk("ar_load_novalid", ar_valid, 0);
      chk("ar_load_busy", ar_busy, 1);
      @(negedge clk);
      chk("ar_valid", ar_valid, 1);
      chk("ar_first", ar_first, 1);
      chk("ar_data", ar_data, exp_byte(0));
      out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
